// File: rtl/velocity_cell_reader_pkg.sv
// Shared types and constants for the velocity cell reader and its skid FIFO.
package velocity_cell_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_RD,
    ST_CNT_WAIT,
    ST_STREAM,
    ST_DRAIN
  } state_e;

  // Velocity word layout: {vz, vy, vx}, 32 bits per component.
  localparam int VEL_W  = 32;
  localparam int VX_LSB = 0;
  localparam int VX_MSB = 31;
  localparam int VY_LSB = 32;
  localparam int VY_MSB = 63;
  localparam int VZ_LSB = 64;
  localparam int VZ_MSB = 95;

  // Word 0 of every cell memory holds the particle count.
  localparam int CNT_ADDR = 0;

  function automatic logic [3*VEL_W-1:0] pack_vel(input logic [VEL_W-1:0] vx,
                                                  input logic [VEL_W-1:0] vy,
                                                  input logic [VEL_W-1:0] vz);
    return {vz, vy, vx};
  endfunction

endpackage

// File: rtl/velocity_cell_reader_skid_fifo.sv
// Two-entry FIFO that catches read data returning one cycle after issue,
// so the stream never loses a word while the consumer stalls.
module vel_skid_fifo #(
  parameter int WIDTH = 105
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             valid_o,
  output logic [1:0]       occ_o
);

  logic [WIDTH-1:0] entry_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       occ_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && (occ_q != 2'd0);
  assign do_push = push_i && ((occ_q != 2'd2) || do_pop);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the two data slots are reset along with the pointers so the stream outputs read 0 after reset.
      entry_q[0] <= '0;
      entry_q[1] <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
    end else begin
      if (do_push) begin
        entry_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head_o  = entry_q[rd_ptr_q];
  assign valid_o = (occ_q != 2'd0);
  assign occ_o   = occ_q;

endmodule

// File: rtl/velocity_cell_reader.sv
// Reads the particle count then streams particles 1..N from one velocity cell
// memory, sharing the port with write-back. Optional macro: VEL_CNT_CLAMP_EN.
module velocity_cell_reader
  import velocity_cell_reader_pkg::*;
#(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_id,
  output logic                  out_last,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic [ADDR_WIDTH-1:0] particle_cnt,
  output logic                  busy,
`ifdef VEL_CNT_CLAMP_EN
  output logic                  cnt_err,
`endif
  output logic                  done
);

  localparam int                    ENTRY_W    = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] CNT_ADDR_A = ADDR_WIDTH'(CNT_ADDR);
  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR   = ADDR_WIDTH'(PARTICLE_NUM - 1);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] cnt_d;
  logic [ADDR_WIDTH-1:0] fly_id_q;
  logic                  fly_q;
  logic                  done_q;

  logic                  cnt_rd_go;
  logic                  stream_rd;
  logic                  wb_hit;
  logic                  pop;
  logic                  fifo_valid;
  logic [1:0]            occ;
  logic [2:0]            credit;
  logic [ENTRY_W-1:0]    head;

  assign pop    = fifo_valid && out_ready;
  assign credit = {1'b0, occ} + {2'b0, fly_q};
  assign wb_hit = (wb_addr != CNT_ADDR_A) && (wb_addr <= MAX_ADDR);

  // A beat leaving this cycle frees its slot, which keeps one read per cycle flowing.
  assign cnt_rd_go = (state_q == ST_CNT_RD) && !wb_valid;
  assign stream_rd = (state_q == ST_STREAM) && !wb_valid &&
                     (credit < (3'd2 + {2'b0, pop}));

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    mem_address = '0;
    mem_data    = '0;
    mem_rden    = 1'b0;
    mem_wren    = 1'b0;
    if (!rst) begin
      if (wb_valid) begin
        if (wb_hit) begin
          mem_wren    = 1'b1;
          mem_address = wb_addr;
          mem_data    = wb_data;
        end
      end else if (cnt_rd_go) begin
        mem_rden    = 1'b1;
        mem_address = CNT_ADDR_A;
      end else if (stream_rd) begin
        mem_rden    = 1'b1;
        mem_address = rd_addr_q;
      end
    end
  end

`ifdef VEL_CNT_CLAMP_EN
  logic cnt_over;
  logic cnt_err_q;

  always_comb begin
    cnt_d    = mem_q[ADDR_WIDTH-1:0];
    cnt_over = (cnt_d > MAX_ADDR);
    if (cnt_over) cnt_d = MAX_ADDR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_err_q <= 1'b0;
    end else if ((state_q == ST_IDLE) && start) begin
      cnt_err_q <= 1'b0;
    end else if ((state_q == ST_CNT_WAIT) && cnt_over) begin
      cnt_err_q <= 1'b1;
    end
  end

  assign cnt_err = cnt_err_q;
`else
  assign cnt_d = mem_q[ADDR_WIDTH-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rd_addr_q <= '0;
      cnt_q     <= '0;
      fly_q     <= 1'b0;
      fly_id_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      fly_q  <= stream_rd;
      if (stream_rd) fly_id_q <= rd_addr_q;
      unique case (state_q)
        ST_IDLE: begin
          if (start) state_q <= ST_CNT_RD;
        end
        ST_CNT_RD: begin
          if (cnt_rd_go) state_q <= ST_CNT_WAIT;
        end
        ST_CNT_WAIT: begin
          cnt_q <= cnt_d;
          if (cnt_d == '0) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            rd_addr_q <= ADDR_WIDTH'(1);
            state_q   <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (stream_rd) begin
            if (rd_addr_q == cnt_q) state_q <= ST_DRAIN;
            else                    rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
          end
        end
        ST_DRAIN: begin
          // Finish as soon as the final beat leaves, not a cycle later.
          if (!fly_q && ((occ == 2'd0) || ((occ == 2'd1) && pop))) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  vel_skid_fifo #(
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fly_q),
    .push_data_i ({(fly_id_q == cnt_q), fly_id_q, mem_q}),
    .pop_i       (pop),
    .head_o      (head),
    .valid_o     (fifo_valid),
    .occ_o       (occ)
  );

  assign {out_last, out_id, out_data} = head;
  assign out_valid    = fifo_valid;
  assign particle_cnt = cnt_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;

endmodule

// File: tb/tb_velocity_cell_reader.sv
// Randomized bench for velocity_cell_reader: a behavioural cell memory plus a
// golden velocity table predicting every streamed beat.
module tb_velocity_cell_reader;
  import velocity_cell_reader_pkg::*;

  localparam int DW = 96;
  localparam int AW = 8;
  localparam int PN = 220;

  logic          clk = 1'b0;
  logic          rst, start, mem_rden, mem_wren, out_valid, out_ready, out_last;
  logic          wb_valid, busy, done;
  logic [AW-1:0] mem_address, out_id, wb_addr, particle_cnt;
  logic [DW-1:0] mem_data, mem_q, out_data, wb_data;
`ifdef VEL_CNT_CLAMP_EN
  logic          cnt_err;
`endif

  always #5 clk = ~clk;

  velocity_cell_reader #(
    .DATA_WIDTH   (DW),
    .PARTICLE_NUM (PN),
    .ADDR_WIDTH   (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .mem_address  (mem_address),
    .mem_data     (mem_data),
    .mem_rden     (mem_rden),
    .mem_wren     (mem_wren),
    .mem_q        (mem_q),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_id       (out_id),
    .out_last     (out_last),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .particle_cnt (particle_cnt),
    .busy         (busy),
`ifdef VEL_CNT_CLAMP_EN
    .cnt_err      (cnt_err),
`endif
    .done         (done)
  );

  // ram is the physical cell memory; gold is what each particle should read as.
  logic [DW-1:0] ram  [256];
  logic [DW-1:0] gold [256];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int exp_n, accepted, issued, start_cyc, done_cyc, first_cyc;
  int acc_cyc[$];
  bit in_pass, done_seen, prev_stall;
  logic [DW-1:0] prev_data, wb4_data;
  logic [AW-1:0] prev_id;
  logic          prev_last;

  bit            pend_rd, pend_wr;
  logic [AW-1:0] pend_rd_addr, pend_wr_addr;
  logic [DW-1:0] pend_wr_data;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_vel();
    return pack_vel($urandom, $urandom, $urandom);
  endfunction

  // Observe one cycle's settled outputs against the model.
  task automatic observe();
    cyc++;
    pend_rd      = mem_rden;
    pend_rd_addr = mem_address;
    pend_wr      = mem_wren;
    pend_wr_addr = mem_address;
    pend_wr_data = mem_data;
    check("port_excl", mem_rden & mem_wren, 1'b0);
    if (wb_valid) begin
      check("wb_rden", mem_rden, 1'b0);
      check("wb_wren", mem_wren, wb_addr != '0);
      if (wb_addr != '0) begin
        check("wb_addr", mem_address, wb_addr);
        check("wb_data", mem_data, wb_data);
        gold[wb_addr] = wb_data;
      end
    end
    if (in_pass) begin
      if (mem_rden && (mem_address != '0)) issued++;
      check("valid_range", out_valid && (accepted >= exp_n), 1'b0);
      if (out_valid && prev_stall) begin
        check("hold_data", out_data, prev_data);
        check("hold_id", out_id, prev_id);
        check("hold_last", out_last, prev_last);
      end
      if (out_valid && out_ready && (accepted < exp_n)) begin
        check("beat_id", out_id, AW'(accepted + 1));
        check("beat_data", out_data, gold[accepted + 1]);
        check("beat_last", out_last, (accepted + 1) == exp_n);
        accepted++;
        acc_cyc.push_back(cyc);
        if (first_cyc < 0) first_cyc = cyc;
      end
      check("outstanding", (issued - accepted) <= 2, 1'b1);
      if (done) begin
        check("done_beats", accepted, exp_n);
        done_seen = 1'b1;
        done_cyc  = cyc;
        in_pass   = 1'b0;
      end
    end else begin
      check("spurious_done", done, 1'b0);
      check("idle_valid", out_valid, 1'b0);
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_id    = out_id;
    prev_last  = out_last;
  endtask

  // One clock: observe before the edge, let the memory answer just after it.
  task automatic cycle();
    #1 observe();
    @(posedge clk);
    #1;
    if (pend_wr) ram[pend_wr_addr] = pend_wr_data;
    if (pend_rd) mem_q = ram[pend_rd_addr];
    @(negedge clk);
  endtask

  task automatic begin_pass(input int n, input bit load);
    int n_eff;
    logic [DW-1:0] v;
    n_eff = n;
`ifdef VEL_CNT_CLAMP_EN
    if (n_eff > PN - 1) n_eff = PN - 1;
`endif
    if (load) begin
      ram[0] = {$urandom, $urandom, 24'($urandom), 8'(n)};
      for (int k = 1; k <= n_eff; k++) begin
        v = rand_vel();
        ram[k]  = v;
        gold[k] = v;
      end
    end
    exp_n     = n_eff;
    accepted  = 0;
    issued    = 0;
    acc_cyc.delete();
    first_cyc = -1;
    done_cyc  = -1;
    done_seen = 1'b0;
    prev_stall = 1'b0;
    in_pass   = 1'b1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    start_cyc = cyc;
  endtask

  // rmode: 0 always ready, 1 ready 1,0,0,..., 2 random. wmode: 0 none, 1 random, 2 addr 4, 3 addr 0.
  task automatic finish_pass(input int rmode, input int wmode);
    for (int t = 0; t < 3000 && !done_seen; t++) begin
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (t % 3 == 0);
        default: out_ready = 1'($urandom_range(1));
      endcase
      wb_valid = 1'b0;
      if (wmode == 2 && t == 2) begin
        wb_valid = 1'b1;
        wb_addr  = AW'(4);
        wb_data  = wb4_data;
      end else if (wmode == 3 && t == 3) begin
        wb_valid = 1'b1;
        wb_addr  = '0;
        wb_data  = {88'($urandom), 8'd9};
      end else if (wmode == 1 && $urandom_range(3) == 0) begin
        if ($urandom_range(4) == 0) begin
          wb_valid = 1'b1;
          wb_addr  = '0;
          wb_data  = rand_vel();
        end else if (accepted + 3 <= PN - 1) begin
          wb_valid = 1'b1;
          wb_addr  = AW'($urandom_range(PN - 1, accepted + 3));
          wb_data  = rand_vel();
        end
      end
      cycle();
    end
    wb_valid = 1'b0;
    check("pass_done", done_seen, 1'b1);
    check("beats", accepted, exp_n);
    check("particle_cnt", particle_cnt, AW'(exp_n));
    check("busy_fall", busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0; mem_q = '0;
    for (int i = 0; i < 256; i++) begin
      ram[i]  = '0;
      gold[i] = '0;
    end
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rden", mem_rden, 1'b0);
    check("rst_wren", mem_wren, 1'b0);
    check("rst_cnt", particle_cnt, '0);
    check("rst_data", out_data, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Count 3, always ready: back-to-back beats, done right after the last.
    begin_pass(3, 1'b1);
    finish_pass(0, 0);
    check("t1_nbeats", acc_cyc.size(), 3);
    if (acc_cyc.size() == 3) begin
      check("t1_gap1", acc_cyc[1] - acc_cyc[0], 1);
      check("t1_gap2", acc_cyc[2] - acc_cyc[1], 1);
      check("t1_done_lat", done_cyc - acc_cyc[2], 1);
      check("t1_first_ge4", (first_cyc - start_cyc) >= 4, 1'b1);
    end

    // Count 0: done two cycles after the count read, never valid.
    begin_pass(0, 1'b1);
    finish_pass(0, 0);
    check("t2_done_lat", done_cyc - start_cyc, 3);

    // Count 5 with ready 1,0,0 pattern.
    begin_pass(5, 1'b1);
    finish_pass(1, 0);

    // Write-back to address 4 before it is read.
    wb4_data = rand_vel();
    begin_pass(5, 1'b1);
    finish_pass(0, 2);
    check("t4_gold4", gold[4], wb4_data);

    // Write-back to address 0 is dropped; count survives to the next pass.
    begin_pass(4, 1'b1);
    finish_pass(2, 3);
    begin_pass(4, 1'b0);
    finish_pass(0, 0);

    // Reset in the middle of a stream.
    begin_pass(5, 1'b1);
    out_ready = 1'b1;
    for (int t = 0; t < 100 && accepted < 2; t++) cycle();
    check("t6_pre_beats", accepted, 2);
    in_pass = 1'b0;
    rst = 1'b1;
    #1;
    check("t6_valid", out_valid, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_done", done, 1'b0);
    check("t6_rden", mem_rden, 1'b0);
    check("t6_cnt", particle_cnt, '0);
    check("t6_id", out_id, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    prev_stall = 1'b0;
    repeat (6) cycle();
    check("t6_idle", busy, 1'b0);
    begin_pass(5, 1'b0);
    finish_pass(0, 0);

    // Randomized passes with random backpressure and write-back.
    repeat (6) begin
      begin_pass($urandom_range(30, 1), 1'b1);
      finish_pass(2, 1);
    end

`ifdef VEL_CNT_CLAMP_EN
    begin_pass(250, 1'b1);
    finish_pass(0, 0);
    check("clamp_err", cnt_err, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/velocity_cell_reader.md
Name: velocity_cell_reader

Overview:
- Sequencer directly upstream-adjacent to one velocity cell memory: drives its single-port address/rden/wren, reads the particle count at address 0, then streams particles 1..N to the velocity cache over valid/ready.
- Also accepts write-back of updated velocities from motion update and arbitrates them onto the same single port.
- Absorbs the RAM's 1-cycle read latency with a 2-entry output buffer, so backpressure never drops data.

Parameters:
- DATA_WIDTH, 96, packed {vz, vy, vx}, 32 bits each.
- PARTICLE_NUM, 220, memory depth in words; address 0 holds the count.
- ADDR_WIDTH, 8, memory address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  1-cycle pulse; begins a cell read pass (ignored unless IDLE).
- mem_address  out  ADDR_WIDTH  to cell memory.
- mem_data  out  DATA_WIDTH  write data to cell memory.
- mem_rden  out  1  read enable.
- mem_wren  out  1  write enable.
- mem_q  in  DATA_WIDTH  read data, valid 1 cycle after rden.
- out_valid  out  1  stream data valid.
- out_ready  in  1  consumer ready.
- out_data  out  DATA_WIDTH  velocity word.
- out_id  out  ADDR_WIDTH  particle address (1..N).
- out_last  out  1  marks particle N.
- wb_valid  in  1  write-back request.
- wb_addr  in  ADDR_WIDTH  write-back address (1..PARTICLE_NUM-1).
- wb_data  in  DATA_WIDTH  write-back velocity.
- particle_cnt  out  ADDR_WIDTH  count latched from address 0.
- busy  out  1  high in any state except IDLE.
- done  out  1  1-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (asynchronous, rst=1): all outputs 0; FSM returns to IDLE; buffer is flushed; in-flight read is discarded. Reset mid-pass aborts the pass with no done pulse.

FSM states:
- IDLE: on start, go to CNT_RD.
- CNT_RD: issue rden at address 0; go to CNT_WAIT.
- CNT_WAIT: latch particle_cnt = mem_q[ADDR_WIDTH-1:0].
  - If count is 0: pulse done and return to IDLE, with no out_valid.
  - Otherwise set next read address to 1 and go to STREAM.
- STREAM: issue a read of the next address when both hold:
  - buffer occupancy + reads in flight < 2;
  - no write-back is being taken that cycle.
  - Returning data enters the buffer with its id; out_last = (id == particle_cnt).
  - After address N has been issued, stop issuing. Go to DRAIN.
- DRAIN: when the buffer is empty and nothing is in flight, pulse done and go to IDLE.

Memory port and write-back:
- Write-back has priority over reads. When wb_valid=1: mem_wren=1, mem_address=wb_addr, mem_data=wb_data, mem_rden=0 that cycle; the pending read slips one cycle.
- wb_valid is always accepted; there is no wb_ready.
- Write-back to address 0 is dropped, and mem_wren stays 0.
- mem_rden and mem_wren are never both 1.
- A write-back in CNT_RD delays the count read by one cycle.

Stream handshake:
- Transfer occurs when out_valid && out_ready.
- out_data, out_id and out_last stay stable while out_valid=1 and out_ready=0.
- Buffer order is FIFO.
- Sustained rate is 1 beat/cycle when out_ready=1 and there are no write-backs.
- First beat appears no earlier than 4 cycles after start: CNT_RD, CNT_WAIT, issue, return.

Counters and wrap:
- The read address counter never exceeds particle_cnt and never wraps.
- start during busy is ignored.
- A write-back to an address not yet streamed returns the new value (read-after-write through memory order).

Optional Feature:
- Macro VEL_CNT_CLAMP_EN.
- With the macro defined: a count greater than PARTICLE_NUM-1 is clamped to PARTICLE_NUM-1, and a sticky output cnt_err (1 bit, cleared by rst or start) is set.
- Without the macro: the raw count is used and no cnt_err port exists. The count is then the caller's responsibility.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, CNT_RD, CNT_WAIT, STREAM, DRAIN);
  - velocity word field offsets (VX 31:0, VY 63:32, VZ 95:64);
  - the count-address constant 0.
- One natural sub-module: vel_skid_fifo, a 2-entry FIFO of {last, id, data} with occupancy output.

Test Plan:
- Count 3, velocities A,B,C at addresses 1..3, out_ready=1 -> beats A(id1), B(id2), C(id3,last=1) on consecutive cycles; done one cycle after C is accepted; busy falls.
- Count 0 -> done pulse 2 cycles after CNT_RD; out_valid never asserted.
- Count 5, out_ready toggling 1,0,0,1,... -> all 5 beats delivered in order; data held stable during stalls; no more than 2 reads outstanding.
- wb_valid at address 4 with data D during the STREAM of count 5, before address 4 is read -> mem_rden=0 that cycle; the stream's beat 4 equals D.
- wb_addr=0 -> mem_wren stays 0 and the count is unchanged on the next pass.
- rst asserted mid-stream after 2 beats -> outputs 0 at once, no done; a new start re-streams from id 1.
- With VEL_CNT_CLAMP_EN defined and count 250 -> particle_cnt=219 and cnt_err=1.
